// File: rtl/pe_pkg.sv
// Shared definitions for the PE input-activation scratchpad: FSM encodings
// and default tile geometry.
package pe_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    READY  = 2'd1,
    STREAM = 2'd2
  } spad_state_e;

  localparam int DATA_BITWIDTH_DEF = 16;
  localparam int KERNEL_SIZE_DEF   = 3;
  localparam int ACT_SIZE_DEF      = 5;

  localparam int TILE_WORDS = ACT_SIZE_DEF * ACT_SIZE_DEF;
  localparam int OUT_DIM    = ACT_SIZE_DEF - KERNEL_SIZE_DEF + 1;

endpackage

// File: rtl/window_addr_gen.sv
// Sliding-window read address generator: walks oy/ox (window origin) and
// ky/kx (offset inside the window), advancing one element per advance pulse.
module window_addr_gen
  import pe_pkg::*;
#(
  parameter int ADDR_BITWIDTH_SPAD = 9,
  parameter int KERNEL_SIZE        = KERNEL_SIZE_DEF,
  parameter int ACT_SIZE           = ACT_SIZE_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          advance,
  output logic [ADDR_BITWIDTH_SPAD-1:0] rd_addr,
  output logic                          last_elem,
  output logic                          last_win
);

  localparam int OUT_N = ACT_SIZE - KERNEL_SIZE + 1;
  localparam logic [ADDR_BITWIDTH_SPAD-1:0] K_MAX = ADDR_BITWIDTH_SPAD'(KERNEL_SIZE - 1);
  localparam logic [ADDR_BITWIDTH_SPAD-1:0] O_MAX = ADDR_BITWIDTH_SPAD'(OUT_N - 1);
  localparam logic [ADDR_BITWIDTH_SPAD-1:0] ROW_W = ADDR_BITWIDTH_SPAD'(ACT_SIZE);

  logic [ADDR_BITWIDTH_SPAD-1:0] oy_q, ox_q, ky_q, kx_q;

  assign last_elem = (ky_q == K_MAX) && (kx_q == K_MAX);
  assign last_win  = (oy_q == O_MAX) && (ox_q == O_MAX);
  assign rd_addr   = (oy_q + ky_q) * ROW_W + (ox_q + kx_q);

  // Advancing past the very last element wraps everything back to zero,
  // so the generator is already positioned for the next replay.
  always_ff @(posedge clk) begin
    if (!reset) begin
      oy_q <= '0;
      ox_q <= '0;
      ky_q <= '0;
      kx_q <= '0;
    end else if (advance) begin
      if (kx_q != K_MAX) begin
        kx_q <= kx_q + 1'b1;
      end else begin
        kx_q <= '0;
        if (ky_q != K_MAX) begin
          ky_q <= ky_q + 1'b1;
        end else begin
          ky_q <= '0;
          if (ox_q != O_MAX) begin
            ox_q <= ox_q + 1'b1;
          end else begin
            ox_q <= '0;
            oy_q <= (oy_q == O_MAX) ? '0 : oy_q + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/spad_iact_window.sv
// Input-activation scratchpad: captures one tile, replays it as sliding windows
// over valid/ready. Optional zero flag output enabled by SPAD_IACT_ZERO_FLAG_EN.
//
// state  | meaning
// LOAD   | capturing tile words at wr_ptr
// READY  | tile complete, waiting for start_conv
// STREAM | replaying windows through the output stage
module spad_iact_window
  import pe_pkg::*;
#(
  parameter int DATA_BITWIDTH      = DATA_BITWIDTH_DEF,
  parameter int ADDR_BITWIDTH_SPAD = 9,
  parameter int KERNEL_SIZE        = KERNEL_SIZE_DEF,
  parameter int ACT_SIZE           = ACT_SIZE_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic signed [DATA_BITWIDTH-1:0] w_data_spad,
  input  logic                            load_en_spad,
  output logic                            load_done,
  input  logic                            start_conv,
  output logic signed [DATA_BITWIDTH-1:0] iact_data,
  output logic                            iact_valid,
  input  logic                            iact_ready,
  output logic                            win_last,
  output logic                            conv_done
`ifdef SPAD_IACT_ZERO_FLAG_EN
  ,
  output logic                            iact_is_zero
`endif
);

  localparam int TILE_N = ACT_SIZE * ACT_SIZE;
  localparam int MEM_AW = (TILE_N > 1) ? $clog2(TILE_N) : 1;
  localparam logic [ADDR_BITWIDTH_SPAD-1:0] LAST_WR  = ADDR_BITWIDTH_SPAD'(TILE_N - 1);
  localparam logic [ADDR_BITWIDTH_SPAD-1:0] TILE_LIM = ADDR_BITWIDTH_SPAD'(TILE_N);

  spad_state_e                     state_q;
  logic [ADDR_BITWIDTH_SPAD-1:0]   wr_ptr_q;
  logic                            load_done_q;
  logic signed [DATA_BITWIDTH-1:0] iact_data_q;
  logic                            iact_valid_q;
  logic                            win_last_q;
  logic                            final_q;
  logic                            conv_done_q;
  logic signed [DATA_BITWIDTH-1:0] mem_q [TILE_N];

  logic [ADDR_BITWIDTH_SPAD-1:0]   rd_addr;
  logic                            last_elem, last_win;
  logic signed [DATA_BITWIDTH-1:0] rd_data;
  logic                            mem_we, xfer, stage_load;

  window_addr_gen #(
    .ADDR_BITWIDTH_SPAD (ADDR_BITWIDTH_SPAD),
    .KERNEL_SIZE        (KERNEL_SIZE),
    .ACT_SIZE           (ACT_SIZE)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .advance   (stage_load),
    .rd_addr   (rd_addr),
    .last_elem (last_elem),
    .last_win  (last_win)
  );

  assign mem_we  = reset && (state_q == LOAD) && load_en_spad && (wr_ptr_q < TILE_LIM);
  assign rd_data = (rd_addr < TILE_LIM) ? mem_q[rd_addr[MEM_AW-1:0]] : '0;
  assign xfer    = iact_valid_q && iact_ready;

  // The stage only empties at end of replay, so in STREAM it refills exactly
  // on a transfer; the first element is preloaded in the start_conv cycle.
  assign stage_load = reset &&
                      (((state_q == READY) && start_conv) ||
                       ((state_q == STREAM) && xfer && !final_q));

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q[MEM_AW-1:0]] <= w_data_spad;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= LOAD;
      wr_ptr_q     <= '0;
      load_done_q  <= 1'b0;
      iact_data_q  <= '0;
      iact_valid_q <= 1'b0;
      win_last_q   <= 1'b0;
      final_q      <= 1'b0;
      conv_done_q  <= 1'b0;
    end else begin
      conv_done_q <= 1'b0;
      case (state_q)
        LOAD: begin
          if (load_en_spad) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            if (wr_ptr_q == LAST_WR) begin
              state_q     <= READY;
              load_done_q <= 1'b1;
            end
          end
        end
        READY: begin
          if (start_conv) begin
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (xfer && final_q) begin
            state_q      <= LOAD;
            wr_ptr_q     <= '0;
            load_done_q  <= 1'b0;
            iact_valid_q <= 1'b0;
            win_last_q   <= 1'b0;
            final_q      <= 1'b0;
            conv_done_q  <= 1'b1;
          end
        end
        default: begin
          state_q      <= LOAD;
          wr_ptr_q     <= '0;
          load_done_q  <= 1'b0;
          iact_valid_q <= 1'b0;
          win_last_q   <= 1'b0;
          final_q      <= 1'b0;
        end
      endcase
      if (stage_load) begin
        iact_data_q  <= rd_data;
        iact_valid_q <= 1'b1;
        win_last_q   <= last_elem;
        final_q      <= last_elem && last_win;
      end
    end
  end

  assign load_done  = load_done_q;
  assign iact_data  = iact_data_q;
  assign iact_valid = iact_valid_q;
  assign win_last   = win_last_q;
  assign conv_done  = conv_done_q;

`ifdef SPAD_IACT_ZERO_FLAG_EN
  logic iact_is_zero_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      iact_is_zero_q <= 1'b0;
    end else if (stage_load) begin
      iact_is_zero_q <= (rd_data == '0);
    end
  end

  assign iact_is_zero = iact_is_zero_q;
`endif

endmodule

// File: tb/tb_spad_iact_window.sv
// Scoreboard bench for spad_iact_window: expected window elements are queued
// at start_conv and popped on each valid/ready transfer.
module tb_spad_iact_window;

  localparam int AS   = 5;
  localparam int KS   = 3;
  localparam int OD   = AS - KS + 1;
  localparam int TILE = AS * AS;
  localparam int NEL  = OD * OD * KS * KS;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] w_data_spad = '0;
  logic        load_en_spad = 1'b0;
  logic        start_conv = 1'b0;
  logic        iact_ready = 1'b0;
  logic        load_done;
  logic [15:0] iact_data;
  logic        iact_valid;
  logic        win_last;
  logic        conv_done;
`ifdef SPAD_IACT_ZERO_FLAG_EN
  logic        iact_is_zero;
`endif

  logic [15:0] tile_mem [TILE];
  logic [17:0] sb_q [$];
  int          n_chk = 0;
  int          n_bad = 0;

  spad_iact_window dut (
    .clk          (clk),
    .reset        (reset),
    .w_data_spad  (w_data_spad),
    .load_en_spad (load_en_spad),
    .load_done    (load_done),
    .start_conv   (start_conv),
    .iact_data    (iact_data),
    .iact_valid   (iact_valid),
    .iact_ready   (iact_ready),
    .win_last     (win_last),
    .conv_done    (conv_done)
`ifdef SPAD_IACT_ZERO_FLAG_EN
    ,
    .iact_is_zero (iact_is_zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic rdy(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c % 2 == 0);
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    load_en_spad = 1'b0;
    start_conv = 1'b0;
    iact_ready = 1'b0;
    @(negedge clk);
    chk("rst_load_done", load_done, 0);
    chk("rst_valid", iact_valid, 0);
    chk("rst_win_last", win_last, 0);
    chk("rst_conv_done", conv_done, 0);
    chk("rst_data", iact_data, 0);
    reset = 1'b1;
  endtask

  // Words past the tile size carry junk that must never reach the output.
  task automatic load_tile(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == TILE - 1) chk("load_done_early", load_done, 0);
      if (i == TILE) chk("load_done_set", load_done, 1);
      chk("load_valid", iact_valid, 0);
      load_en_spad = 1'b1;
      w_data_spad  = (i < TILE) ? tile_mem[i] : 16'h7000 + 16'(i);
      start_conv   = (i == 3);
    end
    @(negedge clk);
    load_en_spad = 1'b0;
    start_conv   = 1'b0;
    if (n >= TILE) chk("load_done_hold", load_done, 1);
  endtask

  task automatic replay(input int mode, input int abort_at, input int exp_zeros);
    logic [17:0] e;
    logic [15:0] hd;
    logic        hl;
    logic        held_v, done, aborted;
    int          xfers, zeros_seen;
    held_v = 0; done = 0; aborted = 0; xfers = 0; zeros_seen = 0;
    sb_q.delete();
    for (int oy = 0; oy < OD; oy++)
      for (int ox = 0; ox < OD; ox++)
        for (int ky = 0; ky < KS; ky++)
          for (int kx = 0; kx < KS; kx++) begin
            e[15:0] = tile_mem[(oy + ky) * AS + ox + kx];
            e[16]   = (ky == KS - 1) && (kx == KS - 1);
            e[17]   = (e[15:0] == 16'h0);
            sb_q.push_back(e);
          end
    @(negedge clk);
    start_conv = 1'b1;
    @(negedge clk);
    start_conv = 1'b0;
    chk("first_valid", iact_valid, 1);
    for (int c = 0; c < 2000 && !done; c++) begin
      iact_ready = rdy(mode, c);
      if (mode == 2) begin
        load_en_spad = 1'b1;
        w_data_spad  = 16'h5A5A;
        start_conv   = (c == 10);
      end
      #1;
      if (held_v) begin
        chk("stall_data", iact_data, hd);
        chk("stall_last", win_last, hl);
        held_v = 0;
      end
      chk("stream_valid", iact_valid, 1);
      chk("early_done", conv_done, 0);
      if (iact_valid && iact_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("data", iact_data, e[15:0]);
          chk("win_last", win_last, e[16]);
`ifdef SPAD_IACT_ZERO_FLAG_EN
          chk("is_zero", iact_is_zero, e[17]);
          if (iact_is_zero) zeros_seen++;
`endif
        end
        xfers++;
        if (xfers == NEL) begin
          done = 1;
          load_en_spad = 1'b0;
          start_conv = 1'b0;
        end else if (abort_at > 0 && xfers == abort_at) begin
          reset = 1'b0;
          aborted = 1;
          done = 1;
        end
      end else if (iact_valid) begin
        held_v = 1;
        hd = iact_data;
        hl = win_last;
      end
      @(negedge clk);
    end
    iact_ready = 1'b0;
    load_en_spad = 1'b0;
    start_conv = 1'b0;
    if (!done) begin
      chk("replay_timeout", 0, 1);
    end else if (aborted) begin
      chk("abort_valid", iact_valid, 0);
      chk("abort_load_done", load_done, 0);
      chk("abort_conv_done", conv_done, 0);
      reset = 1'b1;
      sb_q.delete();
    end else begin
      chk("conv_done", conv_done, 1);
      chk("done_valid", iact_valid, 0);
      chk("done_load_done", load_done, 0);
      chk("sb_left", sb_q.size(), 0);
`ifdef SPAD_IACT_ZERO_FLAG_EN
      chk("zero_count", zeros_seen, exp_zeros);
`endif
      @(negedge clk);
      chk("conv_done_pulse", conv_done, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < TILE; i++) tile_mem[i] = 16'(i + 1);
    do_reset();
    load_tile(TILE);
    replay(0, 0, 0);
    load_tile(TILE);
    replay(1, 0, 0);
    load_tile(TILE + 2);
    replay(0, 0, 0);
    load_tile(TILE);
    replay(2, 0, 0);
    load_tile(TILE);
    replay(0, 40, 0);
    load_tile(TILE);
    replay(0, 0, 0);
`ifdef SPAD_IACT_ZERO_FLAG_EN
    tile_mem[6] = 16'h0;
    load_tile(TILE);
    replay(1, 0, 4);
    tile_mem[6] = 16'h7;
`endif
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spad_iact_window.md
Name: spad_iact_window

Overview:
- PE-side input-activation scratchpad. Sits directly downstream of the GLB iact router.
- Captures the ACT_SIZE x ACT_SIZE activation tile streamed in on w_data_spad/load_en_spad.
- On command, replays it to the PE MAC as a sequence of KERNEL_SIZE x KERNEL_SIZE sliding windows (stride 1, no padding) over a valid/ready handshake.

Parameters:
- DATA_BITWIDTH, 16, activation word width (signed).
- ADDR_BITWIDTH_SPAD, 9, scratchpad address width; requires 2**ADDR_BITWIDTH_SPAD >= ACT_SIZE**2.
- KERNEL_SIZE, 3, window edge length.
- ACT_SIZE, 5, activation tile edge length; requires ACT_SIZE >= KERNEL_SIZE.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous active-low reset (asserted when 0).
- w_data_spad  in  DATA_BITWIDTH  signed activation word from router.
- load_en_spad  in  1  write strobe; w_data_spad is captured on every posedge where this is 1.
- load_done  out  1  level; tile fully loaded (ACT_SIZE**2 words captured).
- start_conv  in  1  one-cycle pulse; begins window replay.
- iact_data  out  DATA_BITWIDTH  signed activation to MAC.
- iact_valid  out  1  iact_data is valid.
- iact_ready  in  1  MAC accepts; a transfer occurs when iact_valid && iact_ready.
- win_last  out  1  qualifies iact_data as the last element of the current window.
- conv_done  out  1  one-cycle pulse after the final element of the final window transfers.

Behaviour:
- Reset (reset==0 at posedge):
  - state=LOAD, wr_ptr=0, all window counters=0.
  - load_done=0, iact_valid=0, win_last=0, conv_done=0, iact_data=0.
  - Memory contents are not cleared.
  - Reset mid-load or mid-replay aborts immediately. The next tile starts at address 0.
- Storage: ACT_SIZE**2-entry register array. Row-major: address = row*ACT_SIZE + col.
- LOAD state:
  - Each load_en_spad=1 writes mem[wr_ptr] and increments wr_ptr.
  - When the write at wr_ptr==ACT_SIZE**2-1 occurs, the next cycle shows load_done=1 and state moves to READY.
  - start_conv in LOAD is ignored.
- READY state:
  - load_done held at 1.
  - Further load_en_spad writes are dropped. No overflow and no pointer wrap.
  - start_conv=1 moves to STREAM and clears all counters.
- STREAM state:
  - Counters nest, outer to inner: oy, ox in 0..ACT_SIZE-KERNEL_SIZE; ky, kx in 0..KERNEL_SIZE-1.
  - Read address = (oy+ky)*ACT_SIZE + (ox+kx). Computed at ADDR_BITWIDTH_SPAD width with no truncation.
  - Output register stage:
    - Loads the next element when the stage is empty (iact_valid==0) or when a transfer occurs in the same cycle.
    - Holds iact_data, iact_valid and win_last stable while iact_valid && !iact_ready.
  - First iact_valid appears 1 cycle after the start_conv cycle. Throughput is one element per cycle under continuous iact_ready.
  - win_last=1 exactly when ky==kx==KERNEL_SIZE-1.
  - Total elements = (ACT_SIZE-KERNEL_SIZE+1)**2 * KERNEL_SIZE**2. With defaults: 81 elements in 9 windows.
- DONE:
  - The cycle after the last element transfers: conv_done=1 for one cycle, iact_valid=0, state returns to LOAD, wr_ptr=0, load_done=0.
  - A load_en_spad in that same cycle is captured at address 0.
- Simultaneous events:
  - start_conv during STREAM is ignored.
  - load_en_spad during STREAM is dropped.
- Illegal state encodings go to LOAD.

Optional Feature:
- Macro SPAD_IACT_ZERO_FLAG_EN.
- When defined:
  - Adds output port iact_is_zero (1 bit), registered alongside iact_data; it is 1 iff iact_data==0.
  - It is held under stall like iact_data and resets to 0.
  - Used by the MAC to gate zero multiplies.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package (pe_pkg): state encodings LOAD/READY/STREAM, the localparams TILE_WORDS = ACT_SIZE**2 and OUT_DIM = ACT_SIZE-KERNEL_SIZE+1, and the DATA_BITWIDTH default.
- One natural sub-module: window_addr_gen, containing the oy/ox/ky/kx counters, address arithmetic, advance input, and last_elem/last_win outputs.
- Storage, load logic and the output stage stay in the top module.

Test Plan:
- Reset then stream 25 words (value = address + 1, load_en contiguous) -> load_done=1 the cycle after the 25th write; mem[0]=1, mem[24]=25.
- Loaded tile, start_conv pulse, iact_ready tied 1 -> 81 transfers; first 9 are 1,2,3,6,7,8,11,12,13; last window ends 19,20,23,24,25; win_last on elements 9,18,…,81; conv_done one cycle after the 81st transfer.
- Same as above but iact_ready toggles 1010… -> identical 81-value sequence; data and win_last held stable while stalled.
- 27 writes in LOAD -> words 26 and 27 dropped; replay output identical to scenario 2.
- Reset driven low at element 40 of replay -> next cycle iact_valid=0, load_done=0; a reload of 25 words and replay gives the full correct sequence.
- With SPAD_IACT_ZERO_FLAG_EN defined, load tile with mem[6]=0 -> iact_is_zero=1 only on the transfers reading address 6 (windows 0,1,3,4; 4 occurrences).
